// File: rtl/simplez_pkg.sv
// Shared constants for the Simplez 12-bit CPU control unit: opcodes, sequencer
// state encodings and ALU function codes.
package simplez_pkg;

    localparam int DATAW = 12;
    localparam int ADDRW = 9;

    localparam logic [2:0] ST   = 3'o0;
    localparam logic [2:0] LD   = 3'o1;
    localparam logic [2:0] ADD  = 3'o2;
    localparam logic [2:0] BR   = 3'o3;
    localparam logic [2:0] BZ   = 3'o4;
    localparam logic [2:0] CLR  = 3'o5;
    localparam logic [2:0] DEC  = 3'o6;
    localparam logic [2:0] HALT = 3'o7;

    typedef enum logic [2:0] {
        R0 = 3'd0,
        R1 = 3'd1,
        I0 = 3'd2,
        I1 = 3'd3,
        O0 = 3'd4,
        O1 = 3'd5,
        H  = 3'd6
    } state_t;

    localparam logic [1:0] ALU_TRA2 = 2'b00;
    localparam logic [1:0] ALU_SUM  = 2'b01;
    localparam logic [1:0] ALU_DEC1 = 2'b10;
    localparam logic [1:0] ALU_CLR  = 2'b11;

endpackage

// File: rtl/simplez_udecode.sv
// Combinational microorder decoder: maps sequencer state, opcode, z flag and
// the memory handshake onto the Simplez datapath control lines.
module simplez_udecode (
    input  logic [2:0] i_state,
    input  logic [2:0] i_opcode,
    input  logic       i_z,
    input  logic       i_mem_rdy,
    input  logic       i_armed,
    output logic       o_lec,
    output logic       o_esc,
    output logic       o_era,
    output logic       o_eri,
    output logic       o_sri,
    output logic       o_incp,
    output logic       o_ecp,
    output logic       o_ccp,
    output logic       o_scp,
    output logic       o_eac,
    output logic       o_sac,
    output logic [1:0] o_alu,
    output logic       o_stop
);
    import simplez_pkg::*;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_lec  = 1'b0;
        o_esc  = 1'b0;
        o_era  = 1'b0;
        o_eri  = 1'b0;
        o_sri  = 1'b0;
        o_incp = 1'b0;
        o_ecp  = 1'b0;
        o_ccp  = 1'b0;
        o_scp  = 1'b0;
        o_eac  = 1'b0;
        o_sac  = 1'b0;
        o_alu  = ALU_TRA2;
        o_stop = 1'b0;
        case (state_t'(i_state))
            R0: o_ccp = 1'b1;
            R1: begin o_scp = 1'b1; o_era = 1'b1; end
            I0: if (i_armed) begin
                o_lec = 1'b1;
                if (i_mem_rdy) begin o_eri = 1'b1; o_incp = 1'b1; end
            end
            I1: case (i_opcode)
                ST, LD, ADD: begin o_sri = 1'b1; o_era = 1'b1; end
                BR:          begin o_sri = 1'b1; o_era = 1'b1; o_ecp = 1'b1; end
                BZ: if (i_z) begin o_sri = 1'b1; o_era = 1'b1; o_ecp = 1'b1; end
                    else     begin o_scp = 1'b1; o_era = 1'b1; end
                CLR: begin o_alu = ALU_CLR;  o_eac = 1'b1; o_scp = 1'b1; o_era = 1'b1; end
                DEC: begin o_alu = ALU_DEC1; o_eac = 1'b1; o_scp = 1'b1; o_era = 1'b1; end
                HALT: ;
            endcase
            // Operand phase: the AC load only fires in the cycle the memory completes.
            O0: case (i_opcode)
                ST:  begin o_sac = 1'b1; o_esc = 1'b1; end
                LD:  begin o_lec = 1'b1; if (i_mem_rdy) begin o_alu = ALU_TRA2; o_eac = 1'b1; end end
                ADD: begin o_lec = 1'b1; if (i_mem_rdy) begin o_alu = ALU_SUM;  o_eac = 1'b1; end end
                default: ;
            endcase
            O1: begin o_scp = 1'b1; o_era = 1'b1; end
            H:  o_stop = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/simplez_seq.sv
// Simplez control unit: falling-edge sequencer with memory wait timeout and
// sticky bus error. Optional single-step control under SIMPLEZ_SEQ_STEP_EN.
module simplez_seq #(
    parameter int TMO   = 15,
    parameter int WAITW = 4
) (
`ifdef SIMPLEZ_SEQ_STEP_EN
    input  logic       step,
`endif
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] opcode,
    input  logic       z,
    input  logic       mem_rdy,
    output logic       lec,
    output logic       esc,
    output logic       era,
    output logic       eri,
    output logic       sri,
    output logic       incp,
    output logic       ecp,
    output logic       ccp,
    output logic       scp,
    output logic       eac,
    output logic       sac,
    output logic [1:0] alu,
    output logic       stop,
    output logic       berr,
    output logic [2:0] state_o
);
    import simplez_pkg::*;

    localparam logic [WAITW-1:0] TMO_W = WAITW'(TMO);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WAITW-1:0] r_wait;
    logic [WAITW-1:0] w_wait_inc;
    logic             r_berr;
    logic             w_armed;
    logic             w_i0_done;
    logic             w_waiting;
    logic             w_timeout;

`ifdef SIMPLEZ_SEQ_STEP_EN
    logic r_step_d;
    logic r_step_arm;

    // A new step edge wins over the clear so an edge coinciding with a fetch is not lost.
    always_ff @(negedge clk) begin
        if (!rstn) begin
            r_step_d   <= 1'b0;
            r_step_arm <= 1'b0;
        end else begin
            r_step_d <= step;
            if (step && !r_step_d) r_step_arm <= 1'b1;
            else if (w_i0_done)    r_step_arm <= 1'b0;
        end
    end

    assign w_armed = r_step_arm;
`else
    assign w_armed = 1'b1;
`endif

    assign w_i0_done  = (r_state == I0) && w_armed && mem_rdy;
    assign w_waiting  = (((r_state == I0) && w_armed) || (r_state == O0)) && !mem_rdy;
    assign w_wait_inc = r_wait + 1'b1;
    assign w_timeout  = (TMO != 0) && w_waiting && (w_wait_inc == TMO_W);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            R0: w_state_nxt = R1;
            R1: w_state_nxt = I0;
            I0: if (w_i0_done) w_state_nxt = I1;
            I1: case (opcode)
                ST, LD, ADD:       w_state_nxt = O0;
                BR, BZ, CLR, DEC:  w_state_nxt = I0;
                HALT:              w_state_nxt = H;
            endcase
            O0: if (mem_rdy) w_state_nxt = O1;
            O1: w_state_nxt = I0;
            H:  w_state_nxt = H;
            default: w_state_nxt = R0;
        endcase
        if (w_timeout) w_state_nxt = H;
    end

    always_ff @(negedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn) begin
            r_state <= R0;
            r_wait  <= '0;
            r_berr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_waiting ? w_wait_inc : '0;
            if (w_timeout) r_berr <= 1'b1;
        end
    end

    simplez_udecode u_udecode (
        .i_state   (r_state),
        .i_opcode  (opcode),
        .i_z       (z),
        .i_mem_rdy (mem_rdy),
        .i_armed   (w_armed),
        .o_lec     (lec),
        .o_esc     (esc),
        .o_era     (era),
        .o_eri     (eri),
        .o_sri     (sri),
        .o_incp    (incp),
        .o_ecp     (ecp),
        .o_ccp     (ccp),
        .o_scp     (scp),
        .o_eac     (eac),
        .o_sac     (sac),
        .o_alu     (alu),
        .o_stop    (stop)
    );

    assign berr    = r_berr;
    assign state_o = r_state;

endmodule

// File: tb/tb_simplez_seq.sv
// Bench for simplez_seq: instruction-level reference script generates the
// expected per-cycle state and microorders for randomized programs.
module tb_simplez_seq;

    localparam logic [2:0] S_R0 = 3'd0, S_R1 = 3'd1, S_I0 = 3'd2, S_I1 = 3'd3;
    localparam logic [2:0] S_O0 = 3'd4, S_O1 = 3'd5, S_H  = 3'd6;
    localparam logic [2:0] C_ST = 3'd0, C_LD = 3'd1, C_ADD = 3'd2, C_BR = 3'd3;
    localparam logic [2:0] C_BZ = 3'd4, C_CLR = 3'd5, C_DEC = 3'd6, C_HALT = 3'd7;

    localparam logic [14:0] U_LEC  = 15'h4000, U_ESC  = 15'h2000, U_ERA  = 15'h1000;
    localparam logic [14:0] U_ERI  = 15'h0800, U_SRI  = 15'h0400, U_INCP = 15'h0200;
    localparam logic [14:0] U_ECP  = 15'h0100, U_CCP  = 15'h0080, U_SCP  = 15'h0040;
    localparam logic [14:0] U_EAC  = 15'h0020, U_SAC  = 15'h0010;
    localparam logic [14:0] U_SUM  = 15'h0004, U_DEC1 = 15'h0008, U_CLR  = 15'h000C;
    localparam logic [14:0] U_STOP = 15'h0002, U_BERR = 15'h0001;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       z = 1'b0;
    logic       mem_rdy = 1'b0;
    logic       step_in = 1'b0;
    logic       lec, esc, era, eri, sri, incp, ecp, ccp, scp, eac, sac, stop, berr;
    logic [1:0] alu;
    logic [2:0] state_o;
    logic [14:0] uo_vec;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  auto_step;

    always #5 clk = ~clk;

    simplez_seq #(.TMO(15), .WAITW(4)) dut (
`ifdef SIMPLEZ_SEQ_STEP_EN
        .step    (step_in),
`endif
        .clk     (clk),
        .rstn    (rstn),
        .opcode  (opcode),
        .z       (z),
        .mem_rdy (mem_rdy),
        .lec     (lec),
        .esc     (esc),
        .era     (era),
        .eri     (eri),
        .sri     (sri),
        .incp    (incp),
        .ecp     (ecp),
        .ccp     (ccp),
        .scp     (scp),
        .eac     (eac),
        .sac     (sac),
        .alu     (alu),
        .stop    (stop),
        .berr    (berr),
        .state_o (state_o)
    );

    assign uo_vec = {lec, esc, era, eri, sri, incp, ecp, ccp, scp, eac, sac, alu, stop, berr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs after the rising edge, check before the falling (active) edge.
    task automatic step_cycle(input string tag, input logic rdy, input logic [2:0] opc,
                              input logic zz, input logic stp,
                              input logic [2:0] exp_st, input logic [14:0] exp_uo);
        @(posedge clk);
        mem_rdy = rdy;
        opcode  = opc;
        z       = zz;
        step_in = stp;
        #1;
        check({tag, "/state"}, 32'(state_o), 32'(exp_st));
        check({tag, "/uo"}, 32'(uo_vec), 32'(exp_uo));
    endtask

    task automatic do_reset();
        @(posedge clk);
        rstn    = 1'b0;
        step_in = 1'b0;
        @(negedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic reset_seq();
        do_reset();
        step_cycle("r0", 1'($urandom), 3'd0, 1'b0, 1'b0, S_R0, U_CCP);
        step_cycle("r1", 1'($urandom), 3'd0, 1'b0, auto_step, S_R1, U_SCP | U_ERA);
    endtask

    // Expected cycles of one instruction, given fetch and operand wait counts.
    task automatic run_instr(input logic [2:0] opc, input logic zz, input int fw, input int ow);
        logic [14:0] dec;
        logic [14:0] opw;
        logic [14:0] opd;
        bit          mem_op;
        mem_op = (opc == C_ST) || (opc == C_LD) || (opc == C_ADD);
        for (int i = 0; i < fw; i++)
            step_cycle("fetch_wait", 1'b0, opc, zz, 1'b0, S_I0, U_LEC);
        step_cycle("fetch", 1'b1, opc, zz, 1'b0, S_I0, U_LEC | U_ERI | U_INCP);
        case (opc)
            C_BR:    dec = U_SRI | U_ERA | U_ECP;
            C_BZ:    dec = zz ? (U_SRI | U_ERA | U_ECP) : (U_SCP | U_ERA);
            C_CLR:   dec = U_CLR | U_EAC | U_SCP | U_ERA;
            C_DEC:   dec = U_DEC1 | U_EAC | U_SCP | U_ERA;
            C_HALT:  dec = 15'h0;
            default: dec = U_SRI | U_ERA;
        endcase
        step_cycle("decode", 1'($urandom), opc, zz,
                   (mem_op || opc == C_HALT) ? 1'b0 : auto_step, S_I1, dec);
        if (mem_op) begin
            opw = (opc == C_ST) ? (U_SAC | U_ESC) : U_LEC;
            opd = (opc == C_ST) ? (U_SAC | U_ESC) :
                  (opc == C_LD) ? (U_LEC | U_EAC) : (U_LEC | U_EAC | U_SUM);
            for (int i = 0; i < ow; i++)
                step_cycle("oper_wait", 1'b0, opc, zz, 1'b0, S_O0, opw);
            step_cycle("oper", 1'b1, opc, zz, 1'b0, S_O0, opd);
            step_cycle("term", 1'($urandom), opc, zz, auto_step, S_O1, U_SCP | U_ERA);
        end
    endtask

    initial begin
`ifdef SIMPLEZ_SEQ_STEP_EN
        auto_step = 1'b1;
`else
        auto_step = 1'b0;
`endif
        reset_seq();

        // Directed: LD, BZ both ways, ADD with 3 operand waits, waits just under timeout.
        run_instr(C_LD, 1'b0, 0, 0);
        run_instr(C_BZ, 1'b1, 0, 0);
        run_instr(C_BZ, 1'b0, 0, 0);
        run_instr(C_ADD, 1'b0, 2, 3);
        run_instr(C_ST, 1'b1, 14, 14);

        // Random program, no HALT.
        for (int n = 0; n < 40; n++) begin
            logic [2:0] opc;
            int fw, ow;
            opc = 3'($urandom_range(0, 6));
            fw  = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
            ow  = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
            run_instr(opc, 1'($urandom), fw, ow);
        end

        // Reset in the middle of an operand wait.
        step_cycle("mid_fetch", 1'b1, C_LD, 1'b0, 1'b0, S_I0, U_LEC | U_ERI | U_INCP);
        step_cycle("mid_dec", 1'b0, C_LD, 1'b0, 1'b0, S_I1, U_SRI | U_ERA);
        step_cycle("mid_wait", 1'b0, C_LD, 1'b0, 1'b0, S_O0, U_LEC);
        reset_seq();

`ifdef SIMPLEZ_SEQ_STEP_EN
        auto_step = 1'b0;
        run_instr(C_BR, 1'b0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++)
                step_cycle("step_idle", 1'($urandom), C_CLR, 1'b0, 1'b0, S_I0, 15'h0);
            step_cycle("step_edge", 1'($urandom), C_CLR, 1'b0, 1'b1, S_I0, 15'h0);
            run_instr(C_CLR, 1'b0, 1, 0);
        end
        for (int i = 0; i < 4; i++)
            step_cycle("step_after", 1'($urandom), C_DEC, 1'b0, 1'b0, S_I0, 15'h0);
        auto_step = 1'b1;
`endif

        // Fetch timeout: 15 wait cycles in I0, then halted with bus error.
        reset_seq();
        for (int i = 0; i < 15; i++)
            step_cycle("tmo_wait", 1'b0, C_LD, 1'b0, 1'b0, S_I0, U_LEC);
        for (int i = 0; i < 3; i++)
            step_cycle("tmo_halt", 1'($urandom), C_LD, 1'b0, 1'b0, S_H, U_STOP | U_BERR);
        reset_seq();

        // Operand timeout.
        run_instr(C_ADD, 1'b0, 0, 0);
        step_cycle("otmo_fetch", 1'b1, C_ADD, 1'b0, 1'b0, S_I0, U_LEC | U_ERI | U_INCP);
        step_cycle("otmo_dec", 1'b0, C_ADD, 1'b0, 1'b0, S_I1, U_SRI | U_ERA);
        for (int i = 0; i < 15; i++)
            step_cycle("otmo_wait", 1'b0, C_ADD, 1'b0, 1'b0, S_O0, U_LEC);
        step_cycle("otmo_halt", 1'b0, C_ADD, 1'b0, 1'b0, S_H, U_STOP | U_BERR);

        // HALT is terminal until reset.
        reset_seq();
        run_instr(C_DEC, 1'b1, 0, 0);
        run_instr(C_HALT, 1'b0, 0, 0);
        for (int i = 0; i < 100; i++)
            step_cycle("halt", 1'($urandom), 3'($urandom), 1'($urandom), 1'b0, S_H, U_STOP);
        reset_seq();
        run_instr(C_LD, 1'b0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
